// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: 32-bit load/store over a 16-bit external SRAM as two half-word
// accesses, plus the MEM/WB pipeline register. Upstream freezes while ready is low.
module mem_stage_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_r_m_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n
);

  // Handshake: an instruction completes on the rising edge where ready=1; while ready=0
  // upstream holds every *_in stable, so the request is never re-sampled mid-access.
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] rd_buf;
  logic        req, is_load, is_store;
  logic [16:0] idx;
  logic        dq_drive;
  logic [15:0] dq_wdata;

  assign req      = mem_r_en_in | mem_w_en_in;
  assign is_store = mem_w_en_in;
  // Both enables high is treated as a store, so the read buffer is left alone.
  assign is_load  = mem_r_en_in & ~mem_w_en_in;
  // Data space starts at byte 1024; the subtraction wraps with no range check.
  assign idx      = 17'((alu_res_in - 32'd1024) >> 2);

  assign sram_dq  = dq_drive ? dq_wdata : 16'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    sram_addr = 18'd0;
    sram_we_n = 1'b1;
    dq_drive  = 1'b0;
    dq_wdata  = 16'd0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_nxt = ACC;
          cnt_nxt   = 3'd0;
        end
      end
      ACC: begin
        cnt_nxt   = cnt + 3'd1;
        sram_addr = (cnt < 3'd2) ? {idx, 1'b0} : {idx, 1'b1};
        if (is_store && cnt <= 3'd3) begin
          sram_we_n = 1'b0;
          dq_drive  = 1'b1;
          dq_wdata  = (cnt < 3'd2) ? val_r_m_in[15:0] : val_r_m_in[31:16];
        end
        if (cnt == 3'd4) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Each half is captured at the end of its second address cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf <= 32'd0;
    end else if (state == ACC && is_load) begin
      if (cnt == 3'd1) rd_buf[15:0]  <= sram_dq;
      if (cnt == 3'd3) rd_buf[31:16] <= sram_dq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= 32'd0;
      mem_data_out <= 32'd0;
      dest_out     <= 4'd0;
    end else if (ready) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= rd_buf;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed instructions, a half-word SRAM model on sram_dq,
// and a scoreboard monitor comparing the MEM/WB register after each completing edge.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] alu_res_in = 32'd0, val_r_m_in = 32'd0;
  logic [3:0]  dest_in = 4'd0;
  logic        wb_en_out, mem_r_en_out, ready, sram_we_n;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;

  logic [15:0] mem [0:255];
  logic [69:0] exp_q[$];
  logic [31:0] rb_model = 32'd0;
  int          checks = 0;
  int          errors = 0;
  logic        pend = 1'b0;

  mem_stage_unit dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in),
    .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .ready(ready), .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: outputs whenever not being written, latches writes on the falling edge
  assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'bz;
  always @(negedge clk) if (!rst && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: an edge taken with ready=1 completes the oldest queued instruction
  always @(negedge clk) begin
    logic [69:0] e;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_en_out", {31'd0, wb_en_out}, {31'd0, e[69]});
          chk("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, e[68]});
          chk("alu_res_out", alu_res_out, e[67:36]);
          chk("mem_data_out", mem_data_out, e[35:4]);
          chk("dest_out", {28'd0, dest_out}, {28'd0, e[3:0]});
        end
      end
      pend = ready;
    end
  end

  // Drive one instruction (also releases reset), push its expected MEM/WB contents,
  // check the SRAM sequence during the freeze, then the freeze length.
  task automatic issue(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] val, input logic [3:0] dest, input int exp_freeze);
    int frz;
    logic [17:0] lo, hi;
    @(posedge clk); #1;
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_r_m_in = val; dest_in = dest;
    rst = 1'b0;
    if (r && !w) rb_model = {mem[hi_idx(alu)], mem[lo_idx(alu)]};
    exp_q.push_back({wb, r, alu, rb_model, dest});
    lo = {17'((alu - 32'd1024) >> 2), 1'b0};
    hi = {17'((alu - 32'd1024) >> 2), 1'b1};
    frz = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready) break;
      if (frz == 0) begin
        chk("idle_addr", {14'd0, sram_addr}, 32'd0);
        chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      end else if (frz <= 4) begin
        chk("acc_addr", {14'd0, sram_addr}, {14'd0, (frz <= 2) ? lo : hi});
        chk("acc_we_n", {31'd0, sram_we_n}, {31'd0, ~w});
        if (w) chk("acc_dq", {16'd0, sram_dq}, {16'd0, (frz <= 2) ? val[15:0] : val[31:16]});
      end else begin
        chk("settle_addr", {14'd0, sram_addr}, {14'd0, hi});
        chk("settle_we_n", {31'd0, sram_we_n}, 32'd1);
      end
      frz++;
    end
    chk("freeze_cycles", frz, exp_freeze);
  endtask

  function automatic logic [7:0] lo_idx(input logic [31:0] alu);
    logic [17:0] a;
    a = {17'((alu - 32'd1024) >> 2), 1'b0};
    return a[7:0];
  endfunction

  function automatic logic [7:0] hi_idx(input logic [31:0] alu);
    logic [17:0] a;
    a = {17'((alu - 32'd1024) >> 2), 1'b1};
    return a[7:0];
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;

    repeat (2) @(negedge clk);
    chk("rst_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("rst_alu_res_out", alu_res_out, 32'd0);
    chk("rst_mem_data_out", mem_data_out, 32'd0);
    chk("rst_dest_out", {28'd0, dest_out}, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);

    issue(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'd0, 4'd3, 0);
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5, 6);        // reads 0xABCD_1234
    issue(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0, 6);
    issue(1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFE_F00D, 4'd1, 6);
    issue(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd2, 6);        // reads back the store
    issue(1'b0, 1'b1, 1'b1, 32'd1036, 32'h0000_0001, 4'd7, 6); // both enables: store
    issue(1'b0, 1'b0, 1'b1, 32'd0, 32'h5555_AAAA, 4'd0, 6);    // wraps to 0x3FE00
    issue(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 4'd9, 0);

    // Abort a store at cnt=2: three edges after its request is presented
    @(posedge clk); #1;
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_res_in = 32'd1040; val_r_m_in = 32'h7777_8888; dest_in = 4'd4;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_addr", {14'd0, sram_addr}, 32'd0);
    chk("abort_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("abort_alu_res_out", alu_res_out, 32'd0);
    chk("abort_dest_out", {28'd0, dest_out}, 32'd0);
    rb_model = 32'd0;

    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5, 6);        // 0xDEAD_BEEF after reset
    @(posedge clk); #1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    @(negedge clk); #1;

    chk("mem2", {16'd0, mem[2]}, 32'h0000_BEEF);
    chk("mem3", {16'd0, mem[3]}, 32'h0000_DEAD);
    chk("mem6", {16'd0, mem[6]}, 32'h0000_0001);
    chk("mem7", {16'd0, mem[7]}, 32'h0000_0000);
    chk("mem_wrap_lo", {16'd0, mem[0]}, 32'h0000_AAAA);
    chk("mem_wrap_hi", {16'd0, mem[1]}, 32'h0000_5555);
    chk("mem_aborted_hi", {16'd0, mem[9]}, 32'h0000_0909);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
